// File: rtl/reset_ctrl_pkg.sv
// Shared types for the system reset controller: FSM states, reset cause codes
// and the registered output bundle decoded from each state.
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SYS_UP = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    typedef struct packed {
        logic sys_rstn;
        logic cpu_rstn;
        logic busy;
    } rst_out_t;

    // Output levels for a given state; unknown encodings behave like HOLD.
    function automatic rst_out_t decode_state(input state_e s);
        rst_out_t o;
        o = '{sys_rstn: 1'b0, cpu_rstn: 1'b0, busy: 1'b1};
        case (s)
            SYS_UP:  o = '{sys_rstn: 1'b1, cpu_rstn: 1'b0, busy: 1'b1};
            RUN:     o = '{sys_rstn: 1'b1, cpu_rstn: 1'b1, busy: 1'b0};
            default: o = '{sys_rstn: 1'b0, cpu_rstn: 1'b0, busy: 1'b1};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/reset_ctrl_rst_sync2.sv
// rst_sync2: two-flop synchronizer with asynchronous active-low reset to 0.
module rst_sync2 (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            meta_q <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/reset_ctrl.sv
// System reset controller: stretches and sequences bus and CPU resets, records
// the last reset cause. Define AUKV_RST_REQ_SYNC_EN to synchronize the requests.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned CPU_DELAY      = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sw_req,
    input  logic       i_wdt_req,
    output logic       o_sys_rstn,
    output logic       o_cpu_rstn,
    output logic [1:0] o_cause,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             arst_n;
    logic             sw_req;
    logic             wdt_req;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_d;
    rst_out_t         out_d;

    rst_sync2 u_rst_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (1'b1),
        .o_q    (arst_n)
    );

`ifdef AUKV_RST_REQ_SYNC_EN
    rst_sync2 u_sw_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_sw_req),
        .o_q    (sw_req)
    );

    rst_sync2 u_wdt_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_wdt_req),
        .o_q    (wdt_req)
    );
`else
    assign sw_req  = i_sw_req;
    assign wdt_req = i_wdt_req;
`endif

    // State, counter and registered outputs; outputs follow the next state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            o_sys_rstn <= 1'b0;
            o_cpu_rstn <= 1'b0;
            o_busy     <= 1'b1;
            o_cause    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_sys_rstn <= out_d.sys_rstn;
            o_cpu_rstn <= out_d.cpu_rstn;
            o_busy     <= out_d.busy;
            o_cause    <= cause_d;
        end
    end

    // Any request restarts the stretch from HOLD; watchdog wins over software.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = o_cause;

        if (arst_n) begin
            if (sw_req || wdt_req) begin
                state_d = HOLD;
                cnt_d   = '0;
                cause_d = wdt_req ? CAUSE_WDT : CAUSE_SW;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (cnt_q == STRETCH_LAST) begin
                            state_d = SYS_UP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    SYS_UP: begin
                        if (cnt_q == DELAY_LAST) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    RUN: begin
                        cnt_d = '0;
                    end
                    default: begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        out_d = decode_state(state_d);
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: expected output changes are queued with the
// cycle they must appear on; a monitor pops and checks each observed change.
module tb_reset_ctrl;

`ifdef AUKV_RST_REQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       i_clk;
    logic       i_rstn;
    logic       i_sw_req;
    logic       i_wdt_req;
    logic       o_sys_rstn;
    logic       o_cpu_rstn;
    logic [1:0] o_cause;
    logic       o_busy;

    typedef struct {
        int         cyc;
        logic [4:0] val;   // {sys, cpu, busy, cause}
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_cmp   = 0;
    int  n_err   = 0;

    reset_ctrl #(
        .STRETCH_CYCLES (16),
        .CPU_DELAY      (8),
        .CNT_W          (8)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_sw_req   (i_sw_req),
        .i_wdt_req  (i_wdt_req),
        .o_sys_rstn (o_sys_rstn),
        .o_cpu_rstn (o_cpu_rstn),
        .o_cause    (o_cause),
        .o_busy     (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void push_ev(input int c, input logic s, input logic cp,
                                    input logic b, input logic [1:0] ca);
        ev_t e;
        e.cyc = c;
        e.val = {s, cp, b, ca};
        exp_q.push_back(e);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge i_clk);
    endtask

    // Request seen by the FSM on edge k, held for n edges.
    task automatic req_at(input int k, input int n, input logic sw, input logic wdt);
        wait_cyc(k - 1 - LAT);
        i_sw_req  = sw;
        i_wdt_req = wdt;
        repeat (n) @(negedge i_clk);
        i_sw_req  = 1'b0;
        i_wdt_req = 1'b0;
    endtask

    // Monitor: check every output change against the queue, plus ordering.
    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        ev_t        e;
        prev = 5'b11011;
        forever begin
            @(posedge i_clk or negedge i_rstn);
            #1;
            n_cmp++;
            if (o_cpu_rstn === 1'b1 && o_sys_rstn !== 1'b1) begin
                n_err++;
                $display("FAIL order: cyc=%0d cpu act=%b while sys act=%b (req cpu=0)",
                         cyc, o_cpu_rstn, o_sys_rstn);
            end
            cur = {o_sys_rstn, o_cpu_rstn, o_busy, o_cause};
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected: cyc=%0d out act=%b req=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        n_err++;
                        $display("FAIL event: cyc act=%0d req=%0d out{sys,cpu,busy,cause} act=%b req=%b",
                                 cyc, e.cyc, cur, e.val);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        i_rstn    = 1'b1;
        i_sw_req  = 1'b0;
        i_wdt_req = 1'b0;

        // Board reset and release
        push_ev(0, 1'b0, 1'b0, 1'b1, 2'b00);
        #1 i_rstn = 1'b0;
        push_ev(21, 1'b1, 1'b0, 1'b1, 2'b00);
        push_ev(29, 1'b1, 1'b1, 1'b0, 2'b00);
        wait_cyc(3);
        i_rstn = 1'b1;

        // Software pulse in RUN
        push_ev(40, 1'b0, 1'b0, 1'b1, 2'b01);
        push_ev(56, 1'b1, 1'b0, 1'b1, 2'b01);
        push_ev(64, 1'b1, 1'b1, 1'b0, 2'b01);
        req_at(40, 1, 1'b1, 1'b0);

        // Simultaneous requests: watchdog cause wins
        push_ev(80, 1'b0, 1'b0, 1'b1, 2'b10);
        push_ev(96, 1'b1, 1'b0, 1'b1, 2'b10);
        push_ev(104, 1'b1, 1'b1, 1'b0, 2'b10);
        req_at(80, 1, 1'b1, 1'b1);

        // Watchdog pulse on the third SYS_UP cycle restarts the stretch
        push_ev(120, 1'b0, 1'b0, 1'b1, 2'b01);
        push_ev(136, 1'b1, 1'b0, 1'b1, 2'b01);
        push_ev(139, 1'b0, 1'b0, 1'b1, 2'b10);
        push_ev(155, 1'b1, 1'b0, 1'b1, 2'b10);
        push_ev(163, 1'b1, 1'b1, 1'b0, 2'b10);
        req_at(120, 1, 1'b1, 1'b0);
        req_at(139, 1, 1'b0, 1'b1);

        // Short board reset between edges during SYS_UP
        push_ev(180, 1'b0, 1'b0, 1'b1, 2'b10);
        push_ev(196, 1'b1, 1'b0, 1'b1, 2'b10);
        push_ev(198, 1'b0, 1'b0, 1'b1, 2'b00);
        push_ev(216, 1'b1, 1'b0, 1'b1, 2'b00);
        push_ev(224, 1'b1, 1'b1, 1'b0, 2'b00);
        req_at(180, 1, 1'b0, 1'b1);
        wait_cyc(198);
        i_rstn = 1'b0;
        #1 i_rstn = 1'b1;

        // Request held for 40 edges keeps the controller in HOLD
        push_ev(240, 1'b0, 1'b0, 1'b1, 2'b01);
        push_ev(295, 1'b1, 1'b0, 1'b1, 2'b01);
        push_ev(303, 1'b1, 1'b1, 1'b0, 2'b01);
        req_at(240, 40, 1'b1, 1'b0);

        wait_cyc(320);
        #2;
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing: event req at cyc=%0d out req=%b act=not seen", e.cyc, e.val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
